// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/MEM requesters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view. The master modport is the requesters' and memory's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_ready;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic                  d_ready;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_gnt, mem_rvalid, mem_rdata,
    output i_ready, i_rdata, d_ready, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_gnt, mem_rvalid, mem_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter onto one single-port memory, one transaction outstanding at a time.
// Data requests win by default. A streak counter bounds how long a waiting fetch can be starved.
//
//   state | meaning
//   IDLE  | no transaction; pick a winner and latch its request fields
//   REQ   | mem_req driven from latched fields until mem_gnt
//   WAIT  | granted; the response on mem_rvalid pulses the owner's ready
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          rstn,
  mem_arbiter_if.slave  bus,
  output logic          if_stall,
  output logic          mem_stall,
  output logic          err_spurious
);

  localparam int         BE_W       = DATA_W / 8;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                own_d_q, own_d_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [3:0]          streak_q, streak_d;
  logic                err_q, err_d;
  logic                pick_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      own_d_q  <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      own_d_q  <= own_d_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      streak_q <= streak_d;
      err_q    <= err_d;
    end
  end

  // Fetch wins only when it is alone or the data streak has hit its limit.
  assign pick_i = bus.i_req & (~bus.d_req | (streak_q == STREAK_MAX));

  always_comb begin
    state_d  = state_q;
    own_d_d  = own_d_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    streak_d = streak_q;
    // Any response outside WAIT is spurious. This includes one arriving alongside mem_gnt in REQ.
    err_d    = err_q | (bus.mem_rvalid & (state_q != ST_WAIT));
    case (state_q)
      ST_IDLE: begin
        if (bus.i_req | bus.d_req) begin
          state_d = ST_REQ;
          if (pick_i) begin
            own_d_d  = 1'b0;
            addr_d   = bus.i_addr;
            we_d     = 1'b0;
            wdata_d  = '0;
            be_d     = '1;
            streak_d = '0;
          end else begin
            own_d_d  = 1'b1;
            addr_d   = bus.d_addr;
            we_d     = bus.d_we;
            wdata_d  = bus.d_wdata;
            be_d     = bus.d_be;
            if (!bus.i_req)
              streak_d = '0;
            else if (streak_q < STREAK_MAX)
              streak_d = streak_q + 4'd1;
          end
        end
      end
      ST_REQ: begin
        if (bus.mem_gnt)
          state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_rvalid)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req   = (state_q == ST_REQ);
    bus.mem_we    = we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.mem_be    = be_q;
    bus.i_rdata   = bus.mem_rdata;
    bus.d_rdata   = bus.mem_rdata;
    bus.i_ready   = 1'b0;
    bus.d_ready   = 1'b0;
    if (state_q == ST_WAIT && bus.mem_rvalid) begin
      bus.i_ready = ~own_d_q;
      bus.d_ready = own_d_q;
    end
    if_stall     = bus.i_req & ~bus.i_ready;
    mem_stall    = bus.d_req & ~bus.d_ready;
    err_spurious = err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions, then hand-written
// sequences for contention, streak fairness, spurious responses and reset abandonment.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic if_stall, mem_stall, err_spurious;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus),
    .if_stall     (if_stall),
    .mem_stall    (mem_stall),
    .err_spurious (err_spurious)
  );

  typedef struct {
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    int          gnt_dly;
    logic [31:0] rdata;
    logic        exp_d;
    logic [31:0] exp_addr, exp_wdata;
    logic        exp_we;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs[5];

  function automatic vec_t mk(input logic ir, input logic dr, input logic dwe,
                              input logic [31:0] ia, input logic [31:0] da,
                              input logic [31:0] dw, input logic [3:0] dbe,
                              input int dly, input logic [31:0] rd,
                              input logic ed, input logic [31:0] ea,
                              input logic [31:0] ew, input logic ewe,
                              input logic [3:0] ebe);
    vec_t v;
    v.i_req = ir;  v.d_req = dr;  v.d_we = dwe;
    v.i_addr = ia; v.d_addr = da; v.d_wdata = dw; v.d_be = dbe;
    v.gnt_dly = dly; v.rdata = rd;
    v.exp_d = ed; v.exp_addr = ea; v.exp_wdata = ew; v.exp_we = ewe; v.exp_be = ebe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    bus.i_req = v.i_req;   bus.i_addr = v.i_addr;
    bus.d_req = v.d_req;   bus.d_we = v.d_we;  bus.d_addr = v.d_addr;
    bus.d_wdata = v.d_wdata; bus.d_be = v.d_be;
    bus.mem_gnt = 1'b0;    bus.mem_rvalid = 1'b0;
    @(negedge clk); #1;
    chk({tag, "_mem_req"}, bus.mem_req, 1'b1);
    chk({tag, "_addr"},    bus.mem_addr, v.exp_addr);
    chk({tag, "_we"},      bus.mem_we, v.exp_we);
    chk({tag, "_be"},      bus.mem_be, v.exp_be);
    if (v.exp_we) chk({tag, "_wdata"}, bus.mem_wdata, v.exp_wdata);
    for (int k = 0; k < v.gnt_dly; k++) begin
      @(negedge clk); #1;
      chk({tag, "_hold_req"},   bus.mem_req, 1'b1);
      chk({tag, "_hold_addr"},  bus.mem_addr, v.exp_addr);
      chk({tag, "_hold_wdata"}, bus.mem_wdata, v.exp_wdata);
      chk({tag, "_hold_be"},    bus.mem_be, v.exp_be);
      chk({tag, "_hold_rdy"},   {bus.i_ready, bus.d_ready}, 2'b00);
    end
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = v.rdata;
    #1;
    chk({tag, "_rdy"},   {bus.i_ready, bus.d_ready}, v.exp_d ? 2'b01 : 2'b10);
    chk({tag, "_rdata"}, v.exp_d ? bus.d_rdata : bus.i_rdata, v.rdata);
    chk({tag, "_wait_req"}, bus.mem_req, 1'b0);
    chk({tag, "_stalls"}, {if_stall, mem_stall},
        {v.i_req & v.exp_d, v.d_req & ~v.exp_d});
    @(negedge clk);
    bus.mem_rvalid = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0;
    #1;
    chk({tag, "_rdy_pulse"}, {bus.i_ready, bus.d_ready}, 2'b00);
  endtask

  // Wait (bounded) for the next mem_req, confirm who was chosen, grant and respond.
  task automatic serve(input string tag, input logic [31:0] exp_addr,
                       input logic exp_d, input logic [31:0] rd);
    bit seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      #1;
      seen = bus.mem_req;
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 1'b0, 1'b1);
      return;
    end
    chk({tag, "_addr"}, bus.mem_addr, exp_addr);
    chk({tag, "_if_stall"}, if_stall, bus.i_req);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = rd;
    #1;
    chk({tag, "_rdy"}, {bus.i_ready, bus.d_ready}, exp_d ? 2'b01 : 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_wdata = 0; bus.d_be = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;

    vecs[0] = mk(1, 0, 0, 32'h100, 32'h0, 32'h0, 4'h0, 0, 32'h00500093,
                 0, 32'h100, 32'h0, 0, 4'hF);
    vecs[1] = mk(0, 1, 1, 32'h0, 32'h3004, 32'hDEADBEEF, 4'b0011, 0, 32'h0,
                 1, 32'h3004, 32'hDEADBEEF, 1, 4'b0011);
    vecs[2] = mk(0, 1, 1, 32'h0, 32'h3010, 32'hCAFEF00D, 4'b1100, 5, 32'h0,
                 1, 32'h3010, 32'hCAFEF00D, 1, 4'b1100);
    vecs[3] = mk(1, 1, 0, 32'h104, 32'h2000, 32'h0, 4'hF, 1, 32'h12345678,
                 1, 32'h2000, 32'h0, 0, 4'hF);
    vecs[4] = mk(1, 0, 0, 32'h108, 32'h0, 32'h0, 4'h0, 2, 32'hA5A5A5A5,
                 0, 32'h108, 32'h0, 0, 4'hF);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_ready", {bus.i_ready, bus.d_ready}, 2'b00);
    chk("rst_err", err_spurious, 1'b0);
    chk("rst_fields", {bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.mem_we}, 69'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Contention: data first, fetch waits stalled until its own ready.
    @(negedge clk);
    bus.i_req = 1; bus.i_addr = 32'h200;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000;
    serve("both_d", 32'h2000, 1'b1, 32'h11);
    chk("both_if_stall", if_stall, 1'b1);
    bus.d_req = 0;
    serve("both_i", 32'h200, 1'b0, 32'h22);
    bus.i_req = 0;

    // Streak limit with both requesters held: D,D,D,D,I,D.
    @(negedge clk);
    bus.mem_rvalid = 0;
    bus.i_req = 1; bus.i_addr = 32'h400;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h500; bus.d_wdata = 32'h5; bus.d_be = 4'hF;
    for (int t = 0; t < 6; t++) begin
      if (t == 4) serve($sformatf("streak%0d", t), 32'h400, 1'b0, 32'h0);
      else        serve($sformatf("streak%0d", t), 32'h500, 1'b1, 32'h0);
    end
    bus.i_req = 0; bus.d_req = 0;

    // Response together with grant in REQ is spurious, the grant still counts.
    @(negedge clk);
    bus.mem_rvalid = 0;
    #1;
    chk("pre_err", err_spurious, 1'b0);
    bus.i_req = 1; bus.i_addr = 32'h600;
    @(negedge clk); #1;
    chk("sp_mem_req", bus.mem_req, 1'b1);
    bus.mem_gnt = 1; bus.mem_rvalid = 1;
    #1;
    chk("sp_no_rdy", {bus.i_ready, bus.d_ready}, 2'b00);
    @(negedge clk);
    bus.mem_gnt = 0; bus.mem_rvalid = 0;
    #1;
    chk("sp_err", err_spurious, 1'b1);
    chk("sp_in_wait", bus.mem_req, 1'b0);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h66;
    #1;
    chk("sp_rdy", bus.i_ready, 1'b1);
    @(negedge clk);
    bus.mem_rvalid = 0; bus.i_req = 0;
    @(negedge clk);
    rstn = 0;
    #1;
    chk("rst_clears_err", err_spurious, 1'b0);
    @(negedge clk);
    rstn = 1;

    // Reset while in WAIT abandons the transaction; the late response is spurious.
    @(negedge clk);
    bus.i_req = 1; bus.i_addr = 32'h700;
    @(negedge clk); #1;
    chk("ab_mem_req", bus.mem_req, 1'b1);
    bus.mem_gnt = 1;
    @(negedge clk);
    bus.mem_gnt = 0;
    #1;
    rstn = 0; bus.i_req = 0;
    #1;
    chk("ab_rst_req", bus.mem_req, 1'b0);
    chk("ab_rst_addr", bus.mem_addr, 32'h0);
    chk("ab_rst_err", err_spurious, 1'b0);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h77;
    #1;
    chk("ab_no_rdy", {bus.i_ready, bus.d_ready}, 2'b00);
    @(negedge clk);
    bus.mem_rvalid = 0;
    #1;
    chk("ab_err", err_spurious, 1'b1);
    chk("ab_idle", bus.mem_req, 1'b0);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h800;
    serve("ab_next", 32'h800, 1'b1, 32'h88);
    bus.d_req = 0;
    @(negedge clk);
    bus.mem_rvalid = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
